// File: rtl/alu4_pin_exerciser.sv
// alu4_pin_exerciser: self-test initiator that sweeps every {op,B,A} vector into the
// 4-bit ALU tile, checks each result against a reference model and reports a summary.
`default_nettype none

module alu4_pin_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       alu_uo,
  output logic [7:0]       alu_ui,
  output logic [7:0]       alu_uio,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [10:0]      first_fail,
  output logic             first_fail_vld
);

  localparam logic [1:0]       C_IDLE    = 2'd0;
  localparam logic [1:0]       C_WAIT    = 2'd1;
  localparam logic [1:0]       C_CHECK   = 2'd2;
  localparam logic [1:0]       C_DONE    = 2'd3;
  localparam logic [3:0]       C_SETTLE  = 4'(SETTLE_CYCLES);
  localparam logic [10:0]      C_LAST    = 11'h7FF;
  localparam logic [ERR_W-1:0] C_ERR_MAX = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [10:0]      r_idx;
  logic [3:0]       r_cnt;
  logic [ERR_W-1:0] r_err;
  logic [10:0]      r_ff;
  logic             r_ffv;
  logic [5:0]       w_expect;
  logic             w_mismatch;
  logic             w_unused;

  function automatic logic [5:0] alu_model(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
    logic [4:0] sum;
    logic [3:0] res;
    logic       carry;
    sum   = {1'b0, a} + {1'b0, b};
    res   = 4'd0;
    carry = 1'b0;
    case (op)
      3'd0: begin res = sum[3:0];          carry = sum[4];  end
      3'd1: begin res = a - b;             carry = (a >= b); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ~a;
      3'd6: begin res = {a[2:0], 1'b0};    carry = a[3];    end
      3'd7: begin res = {1'b0, a[3:1]};    carry = a[0];    end
      default: res = 4'd0;
    endcase
    return {(res == 4'd0), carry, res};
  endfunction

  assign w_expect   = alu_model(r_idx[10:8], r_idx[3:0], r_idx[7:4]);
  assign w_mismatch = (alu_uo[5:0] != w_expect);
  // alu_uo[7:6] carry nothing this block checks
  assign w_unused   = &{1'b0, alu_uo[7:6]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= C_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      C_IDLE:  if (start) w_next = C_WAIT;
      C_WAIT:  if (r_cnt == 4'd1) w_next = C_CHECK;
      C_CHECK: w_next = (r_idx == C_LAST) ? C_DONE : C_WAIT;
      C_DONE:  if (start) w_next = C_WAIT;
      default: w_next = C_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == C_WAIT) || (r_state == C_CHECK);
    done = (r_state == C_DONE);
    pass = done && (r_err == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_err <= '0;
      r_ff  <= '0;
      r_ffv <= 1'b0;
    end else begin
      case (r_state)
        C_IDLE, C_DONE: begin
          if (start) begin
            r_idx <= '0;
            r_cnt <= C_SETTLE;
            r_err <= '0;
            r_ff  <= '0;
            r_ffv <= 1'b0;
          end
        end
        C_WAIT: r_cnt <= r_cnt - 4'd1;
        C_CHECK: begin
          if (w_mismatch) begin
            if (r_err != C_ERR_MAX) r_err <= r_err + 1'b1;
            if (!r_ffv) begin
              r_ff  <= r_idx;
              r_ffv <= 1'b1;
            end
          end
          // The final vector stays on the pins through DONE
          if (r_idx != C_LAST) begin
            r_idx <= r_idx + 11'd1;
            r_cnt <= C_SETTLE;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign alu_ui         = r_idx[7:0];
  assign alu_uio        = {5'b00000, r_idx[10:8]};
  assign err_count      = r_err;
  assign first_fail     = r_ff;
  assign first_fail_vld = r_ffv;

endmodule

`default_nettype wire

// File: doc/alu4_pin_exerciser.md
Name: alu4_pin_exerciser

Overview:
- On-chip self-test initiator for the 4-bit ALU tile. It drives the ALU's dedicated-input and IO-input pins and samples its dedicated outputs.
- It sweeps every opcode/operand combination, compares each result against an internal reference model, and reports a pass/fail summary.
- It sits beside the ALU inside the TinyTapeout wrapper and can be started from a spare input pin.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before its result is sampled; legal range 1..15.
- ERR_W, 12, width of the error counter; the counter saturates at 2^ERR_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- alu_uo  in  8  ALU uo_out: [3:0] result, [4] carry, [5] zero; [7:6] ignored
- alu_ui  out  8  to ALU ui_in: [3:0] A, [7:4] B
- alu_uio  out  8  to ALU uio_in: [2:0] opcode, [7:3] always 0
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  high while in DONE
- pass  out  1  done && err_count==0
- err_count  out  ERR_W  number of mismatching vectors
- first_fail  out  11  {op,B,A} of the first mismatch
- first_fail_vld  out  1  first_fail holds a captured vector

Behaviour:
- Opcode encoding (also the reference-model definition); res is 4 bits, zero = (res==0) for every op:
  - 0 ADD: res = A+B, carry = bit 4 of the sum.
  - 1 SUB: res = A-B, carry = (A>=B).
  - 2 AND, 3 OR, 4 XOR: carry 0.
  - 5 NOT: res = ~A, carry 0.
  - 6 SHL: res = A<<1, carry = A[3].
  - 7 SHR: res = A>>1, carry = A[0].
- Vector index idx[10:0] = {op,B,A}; A increments fastest. Sweep covers idx 0..2047 in order.
- Reset: state=IDLE; alu_ui, alu_uio, busy, done, pass, err_count, first_fail, first_fail_vld all 0.
- FSM IDLE -> WAIT -> CHECK -> (WAIT | DONE); DONE -> WAIT on start.
- IDLE/DONE, start=1:
  - next edge: idx=0; alu_ui/alu_uio driven from idx (registered); err_count=0; first_fail_vld=0; first_fail=0.
  - settle counter loaded with SETTLE_CYCLES; state=WAIT; busy=1; done=0.
- WAIT: counter decrements each cycle; when it reaches 1 the next state is CHECK. Each vector is held SETTLE_CYCLES cycles in WAIT.
- CHECK (1 cycle):
  - Compare alu_uo[5:0] against model{zero,carry,res}.
  - Mismatch: err_count += 1 (saturating). If !first_fail_vld, capture first_fail=idx and set first_fail_vld=1.
  - idx==2047 -> DONE: busy=0, done=1.
  - Otherwise idx+=1, the new vector is driven on the same edge, the counter is reloaded, and state returns to WAIT.
- Timing: SETTLE_CYCLES+1 cycles per vector. done rises 2048*(SETTLE_CYCLES+1) cycles after the start-accept edge.
- start is ignored while busy.
- DONE holds all results and the last vector until start or rst.
- rst mid-sweep: full return to reset values on that edge; no partial results are kept.
- alu_uio[7:3] is always 0. The IO output-enable path is not owned by this block.

Test Plan:
- Golden behavioural ALU on the pins, SETTLE_CYCLES=2, start pulse -> done 6144 cycles after the accept edge; pass=1, err_count=0, first_fail_vld=0.
- alu_uo[4] forced 0 -> err_count=512 (ADD 120, SUB 136, SHL 128, SHR 128); first_fail=11'h01F (ADD, B=1, A=15); pass=0.
- alu_uo[7:6] driven 2'b11 with otherwise golden outputs -> pass=1 (the bits are ignored).
- rst asserted at cycle 100 of a sweep -> next edge all outputs 0 and state IDLE; a new start runs a full clean sweep with pass=1.
- start pulsed again mid-sweep -> ignored; idx sequence unbroken and done timing unchanged.
- start asserted in DONE after a failing run -> err_count and first_fail_vld clear on the accept edge; a golden rerun ends with pass=1.
